multicycle_control_unit: RTL and testbench

- Next-generation control unit for the RV32I core: a multicycle finite-state machine that replaces the single-cycle opcode decoder.
- Sequences fetch, decode, execute, memory and writeback over multiple clocks, sharing one ULA and one memory port.
- Stalls on a memory-ready handshake.
- Counts retired instructions.

---
 rtl/multicycle_control_unit_if.sv | 46 ++++
 rtl/multicycle_control_unit.sv | 266 ++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control/datapath bundle for the multicycle RV32I control unit.
// The datapath side uses the master modport; the control unit uses slave.
// Optional ILLEGAL_TRAP_EN adds the Illegal status line.
interface multicycle_control_unit_if #(
  parameter int ULACTRL_W = 3,
  parameter int CNT_W     = 32
);
  logic [6:0]           OP;
  logic [2:0]           Funct3;
  logic [6:0]           Funct7;
  logic                 Zero;
  logic                 MemReady;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemWrite;
  logic                 IRWrite;
  logic [1:0]           ResultSrc;
  logic [1:0]           ULASrcA;
  logic [1:0]           ULASrcB;
  logic [1:0]           ImmSrc;
  logic [ULACTRL_W-1:0] ULAControl;
  logic                 RegWrite;
  logic [3:0]           State;
  logic [CNT_W-1:0]     Retired;
`ifdef ILLEGAL_TRAP_EN
  logic                 Illegal;
`endif

  modport master (
    output OP, Funct3, Funct7, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ULASrcA, ULASrcB,
           ImmSrc, ULAControl, RegWrite, State, Retired
`ifdef ILLEGAL_TRAP_EN
    , input Illegal
`endif
  );

  modport slave (
    input  OP, Funct3, Funct7, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ULASrcA, ULASrcB,
           ImmSrc, ULAControl, RegWrite, State, Retired
`ifdef ILLEGAL_TRAP_EN
    , output Illegal
`endif
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit for the RV32I core: sequences fetch, decode,
// execute, memory and writeback over several clocks sharing one ULA and one
// memory port, stalls on MemReady and counts retired instructions.
// Optional feature macro: ILLEGAL_TRAP_EN (unknown opcode / funct3 traps
// into a sticky ILLEGAL state and drives the Illegal output).
module multicycle_control_unit #(
  parameter int ULACTRL_W = 3,
  parameter int CNT_W     = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  multicycle_control_unit_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
`ifdef ILLEGAL_TRAP_EN
    , S_ILLEGAL = 4'd11
`endif
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b111;

  // ULA operation from funct3; sub_en selects SUB for funct3 000 (R-type only).
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_en);
    logic [2:0] op;
    case (f3)
      3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
      3'b111:  op = ALU_AND;
      3'b110:  op = ALU_OR;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

`ifdef ILLEGAL_TRAP_EN
  // True for the funct3 codes the ULA decode understands.
  function automatic logic f3_supported(input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b111, 3'b110, 3'b010, 3'b100: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction
`endif

  // Immediate format follows the opcode regardless of state.
  function automatic logic [1:0] imm_decode(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_STORE: imm = 2'b01;
      OP_BEQ:   imm = 2'b10;
      OP_JAL:   imm = 2'b11;
      default:  imm = 2'b00;
    endcase
    return imm;
  endfunction

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] retired_r;
  logic             retire_s;
  logic             pc_write_s;
  logic             adr_src_s;
  logic             mem_write_s;
  logic             ir_write_s;
  logic [1:0]       result_src_s;
  logic [1:0]       src_a_s;
  logic [1:0]       src_b_s;
  logic [2:0]       alu_s;
  logic             reg_write_s;
  logic             unused_f7_s;

  assign unused_f7_s = ^{bus.Funct7[6], bus.Funct7[4:0]};

  // State register and retired counter; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= S_FETCH;
      retired_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (retire_s) begin
        retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  // Next-state and raw control decode for the current state.
  always_comb begin
    next_state_s = S_FETCH;
    retire_s     = 1'b0;
    pc_write_s   = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    result_src_s = 2'b00;
    src_a_s      = 2'b00;
    src_b_s      = 2'b00;
    alu_s        = ALU_ADD;
    reg_write_s  = 1'b0;
    case (state_r)
      S_FETCH: begin
        src_b_s      = 2'b10;
        result_src_s = 2'b10;
        if (bus.MemReady) begin
          ir_write_s   = 1'b1;
          pc_write_s   = 1'b1;
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        src_a_s = 2'b01;
        src_b_s = 2'b01;
        case (bus.OP)
          OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
          OP_RTYPE:          next_state_s = S_EXECR;
          OP_ITYPE:          next_state_s = S_EXECI;
          OP_JAL:            next_state_s = S_JAL;
          OP_BEQ:            next_state_s = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
          default:           next_state_s = S_ILLEGAL;
`else
          default:           next_state_s = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        src_a_s = 2'b10;
        src_b_s = 2'b01;
        if (bus.OP == OP_LOAD) begin
          next_state_s = S_MEMREAD;
        end else begin
          next_state_s = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        adr_src_s = 1'b1;
        if (bus.MemReady) begin
          next_state_s = S_MEMWB;
        end else begin
          next_state_s = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        if (bus.MemReady) begin
          retire_s     = 1'b1;
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEMWRITE;
        end
      end
      S_EXECR: begin
        src_a_s      = 2'b10;
        src_b_s      = 2'b00;
        alu_s        = alu_decode(bus.Funct3, bus.Funct7[5]);
        next_state_s = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
        if (!f3_supported(bus.Funct3)) begin
          next_state_s = S_ILLEGAL;
        end else begin
          next_state_s = S_ALUWB;
        end
`endif
      end
      S_EXECI: begin
        src_a_s      = 2'b10;
        src_b_s      = 2'b01;
        alu_s        = alu_decode(bus.Funct3, 1'b0);
        next_state_s = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
        if (!f3_supported(bus.Funct3)) begin
          next_state_s = S_ILLEGAL;
        end else begin
          next_state_s = S_ALUWB;
        end
`endif
      end
      S_ALUWB: begin
        result_src_s = 2'b00;
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JAL: begin
        src_a_s      = 2'b01;
        src_b_s      = 2'b10;
        result_src_s = 2'b00;
        pc_write_s   = 1'b1;
        next_state_s = S_ALUWB;
      end
      S_BEQ: begin
        src_a_s      = 2'b10;
        src_b_s      = 2'b00;
        alu_s        = ALU_SUB;
        result_src_s = 2'b00;
        pc_write_s   = bus.Zero;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_ILLEGAL: begin
        next_state_s = S_ILLEGAL;
      end
`endif
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

  // While reset is held, enables are gated off and selects show FETCH values.
  assign bus.PCWrite    = rst_n & pc_write_s;
  assign bus.IRWrite    = rst_n & ir_write_s;
  assign bus.MemWrite   = rst_n & mem_write_s;
  assign bus.RegWrite   = rst_n & reg_write_s;
  assign bus.AdrSrc     = rst_n ? adr_src_s : 1'b0;
  assign bus.ResultSrc  = rst_n ? result_src_s : 2'b10;
  assign bus.ULASrcA    = rst_n ? src_a_s : 2'b00;
  assign bus.ULASrcB    = rst_n ? src_b_s : 2'b10;
  assign bus.ULAControl = ULACTRL_W'(rst_n ? alu_s : ALU_ADD);
  assign bus.ImmSrc     = imm_decode(bus.OP);
  assign bus.State      = state_r;
  assign bus.Retired    = retired_r;
`ifdef ILLEGAL_TRAP_EN
  assign bus.Illegal    = (state_r == S_ILLEGAL);
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: each driven cycle pushes the
// expected observable outputs; a negedge monitor pops and compares.
module tb_multicycle_control_unit;
  localparam int ULACTRL_W = 3;
  localparam int CNT_W     = 32;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3,
                 P_MEMWB = 4, P_MEMWRITE = 5, P_EXECR = 6, P_ALUWB = 7,
                 P_EXECI = 8, P_JAL = 9, P_BEQ = 10, P_ILLEGAL = 11;

  typedef struct packed {
    logic [3:0]  state;
    logic        pcw;
    logic        adr;
    logic        mw;
    logic        irw;
    logic [1:0]  res;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [1:0]  imm;
    logic [2:0]  alu;
    logic        regw;
    logic        ill;
    logic [31:0] ret;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.ULACTRL_W(ULACTRL_W), .CNT_W(CNT_W)) bus ();
  multicycle_control_unit #(.ULACTRL_W(ULACTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  obs_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  logic [31:0] retired_m = 32'd0;
  logic [6:0]  cur_op = 7'd0;
  logic [2:0]  cur_f3 = 3'd0;
  logic [6:0]  cur_f7 = 7'd0;
  logic        cur_zero = 1'b0;
  logic [2:0]  alu_tab [8] = '{3'b000, 3'b000, 3'b101, 3'b000,
                               3'b111, 3'b000, 3'b011, 3'b010};

  // Expected outputs for one cycle, straight from the per-state output table.
  function automatic obs_t model(input int ph, input logic mr, input logic rst);
    obs_t o;
    o = '0;
    o.state = 4'(ph);
    o.ret   = retired_m;
    o.ill   = (ph == P_ILLEGAL);
    o.imm   = (cur_op == 7'b0100011) ? 2'b01 :
              (cur_op == 7'b1100011) ? 2'b10 :
              (cur_op == 7'b1101111) ? 2'b11 : 2'b00;
    if (rst) begin
      o.b = 2'b10; o.res = 2'b10;
      return o;
    end
    case (ph)
      P_FETCH:    begin o.b = 2'b10; o.res = 2'b10; o.irw = mr; o.pcw = mr; end
      P_DECODE:   begin o.a = 2'b01; o.b = 2'b01; end
      P_MEMADR:   begin o.a = 2'b10; o.b = 2'b01; end
      P_MEMREAD:  o.adr = 1'b1;
      P_MEMWB:    begin o.res = 2'b01; o.regw = 1'b1; end
      P_MEMWRITE: begin o.adr = 1'b1; o.mw = 1'b1; end
      P_EXECR:    begin
        o.a = 2'b10;
        o.alu = (cur_f3 == 3'd0 && cur_f7[5]) ? 3'b001 : alu_tab[cur_f3];
      end
      P_EXECI:    begin o.a = 2'b10; o.b = 2'b01; o.alu = alu_tab[cur_f3]; end
      P_ALUWB:    o.regw = 1'b1;
      P_JAL:      begin o.a = 2'b01; o.b = 2'b10; o.pcw = 1'b1; end
      P_BEQ:      begin o.a = 2'b10; o.alu = 3'b001; o.pcw = cur_zero; end
      default:    o.state = 4'(ph);
    endcase
    return o;
  endfunction

  // Drive one cycle of inputs just after the edge and record its expectation.
  task automatic cycle(input int ph, input logic mr, input logic rst, input string nm);
    @(posedge clk);
    #1;
    rst_n        = ~rst;
    bus.MemReady = mr;
    bus.OP       = cur_op;
    bus.Funct3   = cur_f3;
    bus.Funct7   = cur_f7;
    bus.Zero     = cur_zero;
    exp_q.push_back(model(ph, mr, rst));
    name_q.push_back(nm);
  endtask

  // A memory-handshake phase: n cycles not ready (random if n<0), then ready.
  task automatic stall_phase(input int ph, input string nm, input int n);
    int k;
    k = (n < 0) ? int'($urandom_range(0, 3)) : n;
    repeat (k) cycle(ph, 1'b0, 1'b0, nm);
    cycle(ph, 1'b1, 1'b0, nm);
  endtask

  task automatic do_reset(input int from_ph, input int n);
    cycle(from_ph, 1'b1, 1'b1, "reset_enter");
    retired_m = 32'd0;
    for (int i = 1; i < n; i++) cycle(P_FETCH, 1'b1, 1'b1, "reset_hold");
  endtask

  task automatic trap_seq();
    repeat (3) cycle(P_ILLEGAL, 1'($urandom_range(0, 1)), 1'b0, "illegal_hold");
    do_reset(P_ILLEGAL, 2);
  endtask

  function automatic logic f3_ok(input logic [2:0] f3);
    return (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd6 || f3 == 3'd7);
  endfunction

  // One instruction through the phase sequence its opcode class implies.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic zero, input int fetch_stall, input int mem_stall,
                           input int abort_ph);
    logic r;
    cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_zero = zero;
    r = 1'($urandom_range(0, 1));
    stall_phase(P_FETCH, "fetch", fetch_stall);
    cycle(P_DECODE, r, 1'b0, "decode");
    case (op)
      7'b0000011: begin
        cycle(P_MEMADR, r, 1'b0, "lw_memadr");
        if (abort_ph == P_MEMREAD) begin
          do_reset(P_MEMREAD, 1);
          return;
        end
        stall_phase(P_MEMREAD, "lw_memread", mem_stall);
        cycle(P_MEMWB, r, 1'b0, "lw_memwb");
        retired_m++;
      end
      7'b0100011: begin
        cycle(P_MEMADR, r, 1'b0, "sw_memadr");
        stall_phase(P_MEMWRITE, "sw_memwrite", mem_stall);
        retired_m++;
      end
      7'b0110011, 7'b0010011: begin
        cycle((op == 7'b0110011) ? P_EXECR : P_EXECI, r, 1'b0, "exec");
`ifdef ILLEGAL_TRAP_EN
        if (!f3_ok(f3)) begin
          trap_seq();
          return;
        end
`endif
        cycle(P_ALUWB, r, 1'b0, "aluwb");
        retired_m++;
      end
      7'b1101111: begin
        cycle(P_JAL, r, 1'b0, "jal");
        cycle(P_ALUWB, r, 1'b0, "jal_aluwb");
        retired_m++;
      end
      7'b1100011: begin
        cycle(P_BEQ, r, 1'b0, "beq");
        retired_m++;
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        trap_seq();
`endif
      end
    endcase
  endtask

  obs_t  mon_e;
  obs_t  mon_a;
  string mon_n;

  // Monitor: compare the DUT outputs against the oldest pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      mon_a = '0;
      mon_a.state = bus.State;
      mon_a.pcw   = bus.PCWrite;
      mon_a.adr   = bus.AdrSrc;
      mon_a.mw    = bus.MemWrite;
      mon_a.irw   = bus.IRWrite;
      mon_a.res   = bus.ResultSrc;
      mon_a.a     = bus.ULASrcA;
      mon_a.b     = bus.ULASrcB;
      mon_a.imm   = bus.ImmSrc;
      mon_a.alu   = bus.ULAControl[2:0];
      mon_a.regw  = bus.RegWrite;
`ifdef ILLEGAL_TRAP_EN
      mon_a.ill   = bus.Illegal;
`endif
      mon_a.ret   = bus.Retired;
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL %s @%0t: got %h expected %h (state %0d vs %0d, ret %0d vs %0d)",
                 mon_n, $time, mon_a, mon_e, mon_a.state, mon_e.state, mon_a.ret, mon_e.ret);
      end
    end
  end

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    int sel;
    rst_n = 1'b0;
    bus.MemReady = 1'b1; bus.OP = 7'd0; bus.Funct3 = 3'd0; bus.Funct7 = 7'd0; bus.Zero = 1'b0;
    do_reset(P_FETCH, 2);
    // Directed cases
    run_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0, 0, 0, -1);  // SUB, no fetch stall
    run_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0, 1, 3, -1);  // LW, 3-cycle stall
    run_instr(7'b0100011, 3'b010, 7'b0000000, 1'b0, 0, 2, -1);  // SW with stall
    run_instr(7'b1100011, 3'b000, 7'b0000000, 1'b1, 0, 0, -1);  // BEQ taken
    run_instr(7'b1100011, 3'b000, 7'b0000000, 1'b0, 0, 0, -1);  // BEQ not taken
    run_instr(7'b1101111, 3'b000, 7'b0000000, 1'b0, 0, 0, -1);  // JAL
    run_instr(7'b0010011, 3'b100, 7'b0100000, 1'b0, 0, 0, -1);  // XORI ignores Funct7
    run_instr(7'b1111111, 3'b000, 7'b0000000, 1'b0, 0, 0, -1);  // unknown opcode
    run_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0, 0, 2, P_MEMREAD); // reset mid-load
    run_instr(7'b0110011, 3'b111, 7'b0000000, 1'b0, 0, 0, -1);  // AND after reset
    // Randomized instruction stream
    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0:       op = 7'b0000011;
        1:       op = 7'b0100011;
        2:       op = 7'b0110011;
        3:       op = 7'b0010011;
        4:       op = 7'b1101111;
        5:       op = 7'b1100011;
        default: op = ($urandom_range(0, 1) == 0) ? 7'b1111111 : 7'b0000000;
      endcase
      f3 = 3'($urandom_range(0, 7));
`ifdef ILLEGAL_TRAP_EN
      if (!f3_ok(f3)) f3 = 3'b000;
`endif
      run_instr(op, f3, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), -1, -1, -1);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
